// File: rtl/oversampler_phase_scan_pkg.sv
// Shared FSM encodings and phase constants for the oversampler phase scanner.
package oversampler_phase_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_COUNT  = 3'd2,
    ST_EVAL   = 3'd3,
    ST_DONE   = 3'd4
  } scan_state_t;

  localparam logic [1:0] PHASE_0 = 2'd0;
  localparam logic [1:0] PHASE_1 = 2'd1;
  localparam logic [1:0] PHASE_2 = 2'd2;
  localparam logic [1:0] PHASE_3 = 2'd3;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/oversampler_phase_scan_min4_idx.sv
// Combinational argmin over four counts; ties resolve to the lowest index.
// Zero latency, no flow control.
module min4_idx #(
  parameter int W = 13
) (
  input  logic [3:0][W-1:0] vals,
  output logic [1:0]        idx,
  output logic [W-1:0]      min_val
);

  logic         lo_sel;
  logic         hi_sel;
  logic [W-1:0] lo_min;
  logic [W-1:0] hi_min;

  // Strict less-than everywhere so an equal later entry never displaces an earlier one.
  always_comb begin
    lo_sel  = (vals[1] < vals[0]);
    lo_min  = lo_sel ? vals[1] : vals[0];
    hi_sel  = (vals[3] < vals[2]);
    hi_min  = hi_sel ? vals[3] : vals[2];
    idx     = {1'b0, lo_sel};
    min_val = lo_min;
    if (hi_min < lo_min) begin
      idx     = {1'b1, hi_sel};
      min_val = hi_min;
    end
  end

endmodule

// File: rtl/oversampler_phase_scan.sv
// Serial phase scanner: per channel tries 4 phases, counts phase_err per dwell, programs the best.
// start->done spans NUM_CH*(4*(SETTLE_CYC+2**DWELL_BITS)+1)+2 cycles; start is ignored while busy.
module oversampler_phase_scan
  import oversampler_phase_scan_pkg::*;
#(
  parameter int NUM_CH     = 24,
  parameter int CH_BITS    = 5,
  parameter int SETTLE_CYC = 8,
  parameter int DWELL_BITS = 12,
  parameter int ERR_THRESH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NUM_CH-1:0]     phase_err,
  output logic [2*NUM_CH-1:0]   phase_sel,
  output logic [NUM_CH-1:0]     locked,
  output logic                  busy,
  output logic                  done,
  output logic [CH_BITS-1:0]    scan_ch
);

  localparam int CNT_W = DWELL_BITS + 1;
  localparam int TMR_W = max2(DWELL_BITS, $clog2(SETTLE_CYC)) + 1;
  localparam logic [TMR_W-1:0]   SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0]   DWELL_LAST  = TMR_W'((1 << DWELL_BITS) - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX     = CNT_W'(1 << DWELL_BITS);
  localparam logic [CNT_W-1:0]   THRESH      = CNT_W'(ERR_THRESH);
  localparam logic [CH_BITS-1:0] LAST_CH     = CH_BITS'(NUM_CH - 1);

  scan_state_t state_q, state_nxt;

  logic [TMR_W-1:0]            tmr_q;
  logic [CH_BITS-1:0]          ch_q;
  logic [1:0]                  ph_q;
  logic [CNT_W-1:0]            cnt_q;
  logic [CNT_W-1:0]            cnt_upd;
  logic [3:0][CNT_W-1:0]       errs_q;
  logic [NUM_CH-1:0][1:0]      sel_q;
  logic [NUM_CH-1:0]           locked_q;

  logic                        err_bit;
  logic                        settle_last;
  logic                        dwell_last;
  logic                        last_ph;
  logic                        last_ch;
  logic [1:0]                  best_idx;
  logic [CNT_W-1:0]            best_val;
  logic                        best_ok;

  assign settle_last = (tmr_q == SETTLE_LAST);
  assign dwell_last  = (tmr_q == DWELL_LAST);
  assign last_ph     = (ph_q == PHASE_3);
  assign last_ch     = (ch_q == LAST_CH);
  assign best_ok     = (best_val <= THRESH);

  // Only the channel under scan feeds the shared counter.
  always_comb begin
    err_bit = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_q == CH_BITS'(i)) err_bit = phase_err[i];
    end
  end

  assign cnt_upd = (err_bit && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;

  min4_idx #(.W(CNT_W)) u_min4 (
    .vals    (errs_q),
    .idx     (best_idx),
    .min_val (best_val)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        busy = 1'b1;
        if (settle_last) state_nxt = ST_COUNT;
      end
      ST_COUNT: begin
        busy = 1'b1;
        if (dwell_last) state_nxt = last_ph ? ST_EVAL : ST_SETTLE;
      end
      ST_EVAL: begin
        busy      = 1'b1;
        state_nxt = last_ch ? ST_DONE : ST_SETTLE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tmr_q    <= '0;
      ch_q     <= '0;
      ph_q     <= PHASE_0;
      cnt_q    <= '0;
      errs_q   <= '0;
      sel_q    <= '0;
      locked_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            tmr_q       <= '0;
            ch_q        <= '0;
            ph_q        <= PHASE_0;
            cnt_q       <= '0;
            sel_q[0]    <= PHASE_0;
            locked_q[0] <= 1'b0;
          end
        end
        ST_SETTLE: begin
          tmr_q <= settle_last ? '0 : tmr_q + 1'b1;
        end
        ST_COUNT: begin
          if (dwell_last) begin
            tmr_q        <= '0;
            cnt_q        <= '0;
            errs_q[ph_q] <= cnt_upd;
            if (!last_ph) begin
              ph_q <= ph_q + 2'd1;
              for (int i = 0; i < NUM_CH; i++) begin
                if (ch_q == CH_BITS'(i)) sel_q[i] <= ph_q + 2'd1;
              end
            end
          end else begin
            tmr_q <= tmr_q + 1'b1;
            cnt_q <= cnt_upd;
          end
        end
        ST_EVAL: begin
          // Commit this channel's result and open the next channel at phase 0, unlocked.
          for (int i = 0; i < NUM_CH; i++) begin
            if (ch_q == CH_BITS'(i)) begin
              sel_q[i]    <= best_idx;
              locked_q[i] <= best_ok;
            end
            if (!last_ch && ((ch_q + 1'b1) == CH_BITS'(i))) begin
              sel_q[i]    <= PHASE_0;
              locked_q[i] <= 1'b0;
            end
          end
          if (!last_ch) begin
            ch_q  <= ch_q + 1'b1;
            ph_q  <= PHASE_0;
            tmr_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign phase_sel = sel_q;
  assign locked    = locked_q;
  assign scan_ch   = ch_q;

endmodule

// File: tb/tb_oversampler_phase_scan.sv
// Bench for oversampler_phase_scan: schedule-based reference model plus directed and random scans.
module tb_oversampler_phase_scan;

  localparam int NUM_CH   = 3;
  localparam int CH_BITS  = 2;
  localparam int SET      = 8;
  localparam int DWB      = 4;
  localparam int THR      = 2;
  localparam int DW       = 1 << DWB;
  localparam int PH       = SET + DW;
  localparam int CHC      = 4 * PH + 1;
  localparam int SCAN_LAT = NUM_CH * CHC + 2;
  localparam int HMAX     = 8192;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic                  start = 1'b0;
  logic [NUM_CH-1:0]     phase_err = '0;
  logic [2*NUM_CH-1:0]   phase_sel;
  logic [NUM_CH-1:0]     locked;
  logic                  busy;
  logic                  done;
  logic [CH_BITS-1:0]    scan_ch;

  always #5 clock = ~clock;

  oversampler_phase_scan #(
    .NUM_CH(NUM_CH), .CH_BITS(CH_BITS), .SETTLE_CYC(SET),
    .DWELL_BITS(DWB), .ERR_THRESH(THR)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .phase_err(phase_err),
    .phase_sel(phase_sel), .locked(locked), .busy(busy), .done(done), .scan_ch(scan_ch)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: o = cycles since the start cycle (start cycle is o=0).
  int                cyc = 0;
  bit                m_active = 1'b0;
  int                m_start = 0;
  int                m_scan_ch = 0;
  int                res_sel [NUM_CH];
  bit                res_lock[NUM_CH];
  int                m_errs  [NUM_CH][4];
  bit                model_valid = 1'b0;
  logic [NUM_CH-1:0] hist [HMAX];

  logic [2*NUM_CH-1:0] exp_sel;
  logic [NUM_CH-1:0]   exp_lock;
  logic                exp_busy;
  logic                exp_done;
  int                  exp_ch;

  // Stimulus modes: 0 quiet, 1 random, 2 stuck, 3 error unless at target phase, 4 per-phase bursts.
  int mode  [NUM_CH];
  int prob  [NUM_CH];
  int target[NUM_CH];
  int burst [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic eval_channel(input int c);
    int best;
    for (int p = 0; p < 4; p++) begin
      m_errs[c][p] = 0;
      for (int j = 0; j < DW; j++)
        m_errs[c][p] += int'(hist[m_start + 1 + c * CHC + p * PH + SET + j][c]);
      if (m_errs[c][p] > DW) m_errs[c][p] = DW;
    end
    best = 0;
    for (int p = 1; p < 4; p++) if (m_errs[c][p] < m_errs[c][best]) best = p;
    res_sel[c]  = best;
    res_lock[c] = (m_errs[c][best] <= THR);
  endtask

  always @(posedge clock) begin : model
    int o, c, r;
    if (cyc < HMAX) hist[cyc] = phase_err;
    if (reset) begin
      m_active  = 1'b0;
      m_scan_ch = 0;
      for (int i = 0; i < NUM_CH; i++) begin res_sel[i] = 0; res_lock[i] = 1'b0; end
      model_valid = 1'b1;
    end else if (start && !m_active) begin
      m_active = 1'b1;
      m_start  = cyc;
    end
    cyc++;
    if (m_active) begin
      o = cyc - m_start;
      if (o >= CHC + 1 && (o - 1) % CHC == 0 && (o - 1) / CHC <= NUM_CH) eval_channel((o - 1) / CHC - 1);
      if (o == SCAN_LAT) begin m_active = 1'b0; m_scan_ch = NUM_CH - 1; end
    end
    exp_busy = 1'b0;
    exp_done = 1'b0;
    exp_ch   = m_scan_ch;
    for (int i = 0; i < NUM_CH; i++) begin
      exp_sel[2*i +: 2] = 2'(res_sel[i]);
      exp_lock[i]       = res_lock[i];
    end
    if (m_active) begin
      o = cyc - m_start;
      if (o >= 1 && o <= NUM_CH * CHC) begin
        c = (o - 1) / CHC;
        r = (o - 1) % CHC;
        exp_busy          = 1'b1;
        exp_ch            = c;
        exp_lock[c]       = 1'b0;
        exp_sel[2*c +: 2] = (r < 4 * PH) ? 2'(r / PH) : 2'd3;
      end else if (o == NUM_CH * CHC + 1) begin
        exp_done = 1'b1;
        exp_ch   = NUM_CH - 1;
      end
    end
  end

  always @(negedge clock) begin
    if (model_valid) begin
      check("phase_sel", phase_sel, exp_sel);
      check("locked", locked, exp_lock);
      check("busy", busy, exp_busy);
      check("done", done, exp_done);
      check("scan_ch", scan_ch, exp_ch);
    end
  end

  function automatic logic drive_bit(input int ch);
    int o, r, p, q;
    case (mode[ch])
      1: return ($urandom_range(0, 99) < prob[ch]);
      2: return 1'b1;
      3: return (phase_sel[2*ch +: 2] != 2'(target[ch]));
      4: begin
        if (!m_active) return 1'b0;
        o = cyc - m_start;
        if (o < 1 || o > NUM_CH * CHC) return 1'b0;
        if ((o - 1) / CHC != ch) return 1'b0;
        r = (o - 1) % CHC;
        if (r >= 4 * PH) return 1'b0;
        p = r / PH;
        q = r % PH;
        if (q < SET) return 1'b1;
        return ((q - SET) < burst[p]);
      end
      default: return 1'b0;
    endcase
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
    for (int ch = 0; ch < NUM_CH; ch++) phase_err[ch] = drive_bit(ch);
  endtask

  // lat counts the start cycle as 1, so done in the expected cycle gives SCAN_LAT.
  task automatic scan(input int restart_at, input bit pulse_in_done, output int lat);
    int k;
    lat = 0;
    start = 1'b1; step(); start = 1'b0;
    k = 2;
    while (lat == 0 && k <= SCAN_LAT + 50) begin
      if (done === 1'b1) lat = k;
      else begin
        start = (k == restart_at);
        step();
        start = 1'b0;
        k++;
      end
    end
    if (pulse_in_done) start = 1'b1;
    step(); start = 1'b0;
    step();
    check("idle_after_done", busy, 1'b0);
    repeat (3) step();
  endtask

  task automatic set_quiet();
    for (int i = 0; i < NUM_CH; i++) begin mode[i] = 0; prob[i] = 0; target[i] = 0; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nd;
    set_quiet();
    for (int p = 0; p < 4; p++) burst[p] = 0;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    check("rst_phase_sel", phase_sel, 6'd0);
    check("rst_locked", locked, 3'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_scan_ch", scan_ch, 2'd0);
    repeat (2) step();

    // All quiet: every channel locks at phase 0.
    scan(0, 1'b0, lat);
    check("t1_latency", lat, 293);
    check("t1_phase_sel", phase_sel, 6'd0);
    check("t1_locked", locked, 3'b111);

    // ch1 only clean at phase 2.
    mode[1] = 3; target[1] = 2;
    scan(0, 1'b0, lat);
    check("t2_latency", lat, SCAN_LAT);
    check("t2_sel_ch1", phase_sel[3:2], 2'd2);
    check("t2_sel_ch0", phase_sel[1:0], 2'd0);
    check("t2_sel_ch2", phase_sel[5:4], 2'd0);
    check("t2_locked", locked, 3'b111);

    // ch2 stuck: all counts saturate at 16, tie resolves to phase 0.
    set_quiet(); mode[2] = 2;
    scan(0, 1'b0, lat);
    for (int p = 0; p < 4; p++) check("t3_model_errs", m_errs[2][p], 16);
    check("t3_sel_ch2", phase_sel[5:4], 2'd0);
    check("t3_locked", locked, 3'b011);

    // ch0 bursts 5,3,3,9 (settle cycles also erroring): phase 1 wins the tie, unlocked.
    set_quiet(); mode[0] = 4;
    burst[0] = 5; burst[1] = 3; burst[2] = 3; burst[3] = 9;
    scan(0, 1'b0, lat);
    check("t4_model_e0", m_errs[0][0], 5);
    check("t4_model_e1", m_errs[0][1], 3);
    check("t4_model_e3", m_errs[0][3], 9);
    check("t4_sel_ch0", phase_sel[1:0], 2'd1);
    check("t4_locked0", locked[0], 1'b0);

    // Restart attempt at cycle 50 and start during DONE are both ignored.
    for (int i = 0; i < NUM_CH; i++) begin mode[i] = 1; prob[i] = 20; end
    scan(50, 1'b1, lat);
    check("t5_latency", lat, 293);

    // Reset in the middle of ch1's scan.
    start = 1'b1; step(); start = 1'b0;
    for (int k = 2; k < CHC + 40; k++) step();
    check("t6_scan_ch_mid", scan_ch, 2'd1);
    check("t6_busy_mid", busy, 1'b1);
    reset = 1'b1; step(); reset = 1'b0;
    check("t6_phase_sel", phase_sel, 6'd0);
    check("t6_locked", locked, 3'd0);
    check("t6_busy", busy, 1'b0);
    check("t6_done", done, 1'b0);
    nd = 0;
    repeat (20) begin step(); if (done === 1'b1) nd++; end
    check("t6_no_done", nd, 0);
    scan(0, 1'b0, lat);
    check("t6_fresh_latency", lat, SCAN_LAT);

    // Random scans with random stray starts.
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        mode[i]   = $urandom_range(0, 3);
        prob[i]   = $urandom_range(0, 60);
        target[i] = $urandom_range(0, 3);
      end
      if ($urandom_range(0, 1) == 1) begin
        mode[$urandom_range(0, NUM_CH - 1)] = 4;
        for (int p = 0; p < 4; p++) burst[p] = $urandom_range(0, DW);
      end
      scan($urandom_range(2, SCAN_LAT - 1), 1'($urandom_range(0, 1)), lat);
      check("rand_latency", lat, SCAN_LAT);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
